// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction fetch queue between the instruction memory and decode.
//
// Issues aligned FETCH_WIDTH-bit reads to imem, unpacks each response into
// 32-bit instructions (with their PCs) and holds them in a circular queue of
// DEPTH entries. Up to MULTI_ISSUE of the oldest entries are presented to decode
// per cycle; decode reports how many it took through consume_cnt_i.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   imem_busy_i     : memory cannot accept a request this cycle
//   imem_rdy_i      : imem_rd_data_i is valid this cycle
//   imem_rd_data_i  : read data, lower address in bits [31:0]
//   imem_rd_en_o    : read request
//   imem_addr_o     : request address, aligned to FETCH_WIDTH/8 bytes
//   redirect_en_i   : branch redirect / flush
//   redirect_pc_i   : redirect target (4-byte aligned)
//   inst_valid_o    : slot i holds a valid instruction (slot 0 oldest)
//   inst_o          : instruction word per slot
//   inst_pc_o       : PC per slot
//   consume_cnt_i   : number of slots taken this cycle, oldest first
module fetch_buffer #(
  parameter int                     DATA_WIDTH  = 64,
  parameter int                     FETCH_WIDTH = 64,
  parameter int                     MULTI_ISSUE = 2,
  parameter int                     DEPTH       = 8,
  parameter logic [DATA_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  imem_busy_i,
  input  logic                                  imem_rdy_i,
  input  logic [FETCH_WIDTH-1:0]                imem_rd_data_i,
  output logic                                  imem_rd_en_o,
  output logic [DATA_WIDTH-1:0]                 imem_addr_o,
  input  logic                                  redirect_en_i,
  input  logic [DATA_WIDTH-1:0]                 redirect_pc_i,
  output logic [MULTI_ISSUE-1:0]                inst_valid_o,
  output logic [MULTI_ISSUE-1:0][31:0]          inst_o,
  output logic [MULTI_ISSUE-1:0][DATA_WIDTH-1:0] inst_pc_o,
  input  logic [$clog2(MULTI_ISSUE):0]          consume_cnt_i
);

  localparam int NI    = FETCH_WIDTH / 32;
  localparam int OFF_W = $clog2(FETCH_WIDTH / 8);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]            inst_mem_q [DEPTH];
  logic [31:0]            inst_mem_d [DEPTH];
  logic [DATA_WIDTH-1:0]  pc_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]  pc_mem_d [DEPTH];

  logic [DATA_WIDTH-1:0]  line_addr;
  logic [CNT_W-1:0]       free_cnt;
  logic [31:0]            avail;
  logic [31:0]            cons_req;
  logic [31:0]            cons_amt;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       wr_cnt;
  logic [DATA_WIDTH-1:0]  ins_pc;

  assign line_addr    = {fetch_pc_q[DATA_WIDTH-1:OFF_W], OFF_W'(0)};
  assign imem_addr_o  = line_addr;
  assign free_cnt     = CNT_W'(DEPTH) - count_q;
  // Requesting only with room for a whole word means a response can never overflow.
  assign imem_rd_en_o = (state_q == S_IDLE) && !redirect_en_i && !rst &&
                        (free_cnt >= CNT_W'(NI));

  // Presentation: slot i is entry head+i, wrapping naturally in PTR_W bits.
  always_comb begin
    for (int i = 0; i < MULTI_ISSUE; i++) begin
      inst_valid_o[i] = !rst && (count_q > CNT_W'(i));
      inst_o[i]       = inst_mem_q[head_q + PTR_W'(i)];
      inst_pc_o[i]    = pc_mem_q[head_q + PTR_W'(i)];
    end
  end

  // Consume is clamped to what is actually presented.
  always_comb begin
    avail    = (32'(count_q) > 32'(MULTI_ISSUE)) ? 32'(MULTI_ISSUE) : 32'(count_q);
    cons_req = 32'(consume_cnt_i);
    cons_amt = (cons_req > avail) ? avail : cons_req;
  end

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    wr_ptr     = tail_q;
    wr_cnt     = '0;
    ins_pc     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (imem_rd_en_o && !imem_busy_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rdy_i) begin
          // Instructions below fetch_pc belong to the line but precede a
          // redirect target that landed mid-line; they are skipped.
          for (int k = 0; k < NI; k++) begin
            ins_pc = line_addr + DATA_WIDTH'(4 * k);
            if (ins_pc >= fetch_pc_q) begin
              inst_mem_d[wr_ptr] = imem_rd_data_i[32*k +: 32];
              pc_mem_d[wr_ptr]   = ins_pc;
              wr_ptr             = wr_ptr + PTR_W'(1);
              wr_cnt             = wr_cnt + CNT_W'(1);
            end
          end
          fetch_pc_d = line_addr + DATA_WIDTH'(FETCH_WIDTH / 8);
          state_d    = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (imem_rdy_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    tail_d  = wr_ptr;
    head_d  = head_q + PTR_W'(cons_amt);
    count_d = count_q + wr_cnt - CNT_W'(cons_amt);

    // Redirect wins over consume and response. If the outstanding response
    // arrives in the same cycle it is already dropped here, so there is
    // nothing left to discard and the FSM returns to IDLE.
    if (redirect_en_i) begin
      head_d     = tail_q;
      tail_d     = tail_q;
      count_d    = '0;
      fetch_pc_d = redirect_pc_i;
      if (state_q == S_IDLE || imem_rdy_i) state_d = S_IDLE;
      else                                 state_d = S_DISCARD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Queue storage carries no reset; entries are only observed through count.
  always_ff @(posedge clk) begin
    inst_mem_q <= inst_mem_d;
    pc_mem_q   <= pc_mem_d;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed bench for fetch_buffer at default parameters.
module tb_fetch_buffer;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_busy_i;
  logic              imem_rdy_i;
  logic [63:0]       imem_rd_data_i;
  logic              imem_rd_en_o;
  logic [63:0]       imem_addr_o;
  logic              redirect_en_i;
  logic [63:0]       redirect_pc_i;
  logic [1:0]        inst_valid_o;
  logic [1:0][31:0]  inst_o;
  logic [1:0][63:0]  inst_pc_o;
  logic [1:0]        consume_cnt_i;

  int checks   = 0;
  int failures = 0;

  fetch_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .imem_busy_i    (imem_busy_i),
    .imem_rdy_i     (imem_rdy_i),
    .imem_rd_data_i (imem_rd_data_i),
    .imem_rd_en_o   (imem_rd_en_o),
    .imem_addr_o    (imem_addr_o),
    .redirect_en_i  (redirect_en_i),
    .redirect_pc_i  (redirect_pc_i),
    .inst_valid_o   (inst_valid_o),
    .inst_o         (inst_o),
    .inst_pc_o      (inst_pc_o),
    .consume_cnt_i  (consume_cnt_i)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Distinct instruction word per PC.
  function automatic logic [31:0] xi(input logic [63:0] pc);
    return 32'hA000_0000 | pc[31:0];
  endfunction

  function automatic logic [63:0] word_at(input logic [63:0] a);
    return {xi(a + 64'd4), xi(a)};
  endfunction

  // Expects a request to be pending now; accepts it, waits one idle cycle,
  // then returns the response with the given consume in the response cycle.
  task automatic fetch_word(input logic [63:0] addr, input logic [63:0] data,
                            input logic [1:0] cons);
    check_eq("req_en", {63'd0, imem_rd_en_o}, 64'd1);
    check_eq("req_addr", imem_addr_o, addr);
    tick();
    #1 check_eq("wait_no_req", {63'd0, imem_rd_en_o}, 64'd0);
    tick();
    imem_rdy_i     = 1'b1;
    imem_rd_data_i = data;
    consume_cnt_i  = cons;
    tick();
    imem_rdy_i     = 1'b0;
    consume_cnt_i  = 2'd0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    imem_busy_i    = 1'b0;
    imem_rdy_i     = 1'b0;
    imem_rd_data_i = '0;
    redirect_en_i  = 1'b0;
    redirect_pc_i  = '0;
    consume_cnt_i  = 2'd0;
    tick();
    tick();
    #1;
    check_eq("rst_rd_en", {63'd0, imem_rd_en_o}, 64'd0);
    check_eq("rst_valid", {62'd0, inst_valid_o}, 64'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_valid", {62'd0, inst_valid_o}, 64'd0);

    // First fetch after reset.
    fetch_word(64'd0, 64'h00000013_00100093, 2'd0);
    check_eq("t1_valid", {62'd0, inst_valid_o}, 64'd3);
    check_eq("t1_inst0", {32'd0, inst_o[0]}, 64'h00100093);
    check_eq("t1_pc0", inst_pc_o[0], 64'd0);
    check_eq("t1_inst1", {32'd0, inst_o[1]}, 64'h00000013);
    check_eq("t1_pc1", inst_pc_o[1], 64'd4);
    check_eq("t1_next_addr", imem_addr_o, 64'd8);

    // Fill to capacity with no consume.
    fetch_word(64'd8,  word_at(64'd8),  2'd0);
    fetch_word(64'd16, word_at(64'd16), 2'd0);
    fetch_word(64'd24, word_at(64'd24), 2'd0);
    check_eq("full_count", 64'(dut.count_q), 64'd8);
    check_eq("full_no_req", {63'd0, imem_rd_en_o}, 64'd0);
    tick(); tick(); tick();
    check_eq("full_hold_no_req", {63'd0, imem_rd_en_o}, 64'd0);
    check_eq("full_inst0", {32'd0, inst_o[0]}, 64'h00100093);
    consume_cnt_i = 2'd2;
    tick();
    consume_cnt_i = 2'd0;
    #1;
    check_eq("after_cons_count", 64'(dut.count_q), 64'd6);
    fetch_word(64'd32, word_at(64'd32), 2'd0);

    // Drain in order across the pointer wrap.
    imem_busy_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_eq("drain_pc0", inst_pc_o[0], 64'(8 + 8 * k));
      check_eq("drain_inst0", {32'd0, inst_o[0]}, {32'd0, xi(64'(8 + 8 * k))});
      check_eq("drain_inst1", {32'd0, inst_o[1]}, {32'd0, xi(64'(12 + 8 * k))});
      consume_cnt_i = 2'd2;
      tick();
      consume_cnt_i = 2'd0;
      #1;
    end
    check_eq("drain_count", 64'(dut.count_q), 64'd0);
    check_eq("drain_valid", {62'd0, inst_valid_o}, 64'd0);

    // Busy held high: request stays stable and unaccepted.
    for (int k = 0; k < 5; k++) begin
      check_eq("busy_rd_en", {63'd0, imem_rd_en_o}, 64'd1);
      check_eq("busy_addr", imem_addr_o, 64'd40);
      tick();
    end
    imem_busy_i = 1'b0;
    fetch_word(64'd40, word_at(64'd40), 2'd0);
    check_eq("busy_resp_valid", {62'd0, inst_valid_o}, 64'd3);
    check_eq("busy_resp_pc0", inst_pc_o[0], 64'd40);

    // Redirect while a request is outstanding.
    tick();
    redirect_en_i = 1'b1;
    redirect_pc_i = 64'h104;
    #1 check_eq("redir_no_req", {63'd0, imem_rd_en_o}, 64'd0);
    tick();
    redirect_en_i = 1'b0;
    #1;
    check_eq("redir_flush", {62'd0, inst_valid_o}, 64'd0);
    check_eq("discard_no_req", {63'd0, imem_rd_en_o}, 64'd0);
    imem_rdy_i     = 1'b1;
    imem_rd_data_i = word_at(64'd48);
    tick();
    imem_rdy_i = 1'b0;
    #1;
    check_eq("stale_dropped", {62'd0, inst_valid_o}, 64'd0);
    fetch_word(64'h100, word_at(64'h100), 2'd0);
    check_eq("redir_valid", {62'd0, inst_valid_o}, 64'd1);
    check_eq("redir_inst0", {32'd0, inst_o[0]}, {32'd0, xi(64'h104)});
    check_eq("redir_pc0", inst_pc_o[0], 64'h104);

    // Response and consume in the same cycle, wrapping the tail.
    fetch_word(64'h108, word_at(64'h108), 2'd0);
    check_eq("pre_mix_count", 64'(dut.count_q), 64'd3);
    fetch_word(64'h110, word_at(64'h110), 2'd2);
    imem_busy_i = 1'b1;
    check_eq("mix_count", 64'(dut.count_q), 64'd3);
    check_eq("mix_pc0", inst_pc_o[0], 64'h10C);
    check_eq("mix_inst0", {32'd0, inst_o[0]}, {32'd0, xi(64'h10C)});
    check_eq("mix_pc1", inst_pc_o[1], 64'h110);
    consume_cnt_i = 2'd1;
    tick();
    consume_cnt_i = 2'd0;
    #1;
    check_eq("wrap_pc0", inst_pc_o[0], 64'h110);
    check_eq("wrap_pc1", inst_pc_o[1], 64'h114);
    check_eq("wrap_inst1", {32'd0, inst_o[1]}, {32'd0, xi(64'h114)});

    // Over-consume is clamped.
    consume_cnt_i = 2'd1;
    tick();
    consume_cnt_i = 2'd0;
    #1;
    check_eq("clamp_pre_valid", {62'd0, inst_valid_o}, 64'd1);
    consume_cnt_i = 2'd2;
    tick();
    consume_cnt_i = 2'd0;
    #1;
    check_eq("clamp_count", 64'(dut.count_q), 64'd0);
    check_eq("clamp_valid", {62'd0, inst_valid_o}, 64'd0);

    // Reset with a request outstanding and a simultaneous redirect.
    imem_busy_i = 1'b0;
    check_eq("pre_rst_addr", imem_addr_o, 64'h118);
    tick();
    rst           = 1'b1;
    redirect_en_i = 1'b1;
    redirect_pc_i = 64'h200;
    #1;
    check_eq("rst2_rd_en", {63'd0, imem_rd_en_o}, 64'd0);
    tick();
    tick();
    rst           = 1'b0;
    redirect_en_i = 1'b0;
    imem_busy_i   = 1'b1;
    #1;
    check_eq("rst2_addr", imem_addr_o, 64'd0);
    check_eq("rst2_rd_en_after", {63'd0, imem_rd_en_o}, 64'd1);
    imem_rdy_i     = 1'b1;
    imem_rd_data_i = word_at(64'h118);
    tick();
    imem_rdy_i = 1'b0;
    #1;
    check_eq("rst2_stale_valid", {62'd0, inst_valid_o}, 64'd0);
    check_eq("rst2_stale_count", 64'(dut.count_q), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: address and PC width.
REQ-002 SHALL have parameter FETCH_WIDTH, default 64: imem word width; holds FETCH_WIDTH/32 instructions (2 at default).
REQ-003 SHALL have parameter MULTI_ISSUE, default 2: number of instruction slots presented per cycle.
REQ-004 SHALL have parameter DEPTH, default 8: queue capacity in 32-bit instructions; power of two, at least FETCH_WIDTH/32.
REQ-005 SHALL have parameter RESET_PC, default 0: fetch PC after reset.
REQ-006 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port imem_busy_i, input, 1: memory cannot accept a request this cycle.
REQ-009 SHALL have port imem_rdy_i, input, 1: read data valid for one cycle.
REQ-010 SHALL have port imem_rd_data_i, input, FETCH_WIDTH: read data, little-endian; lower address in bits [31:0].
REQ-011 SHALL have port imem_rd_en_o, output, 1: read request.
REQ-012 SHALL have port imem_addr_o, output, DATA_WIDTH: request address, FETCH_WIDTH/8-byte aligned.
REQ-013 SHALL have port redirect_en_i, input, 1: branch redirect or flush.
REQ-014 SHALL have port redirect_pc_i, input, DATA_WIDTH: redirect target, 4-byte aligned.
REQ-015 SHALL have port inst_valid_o, output, MULTI_ISSUE x 1: slot i holds a valid instruction.
REQ-016 SHALL have port inst_o, output, MULTI_ISSUE x 32: instruction word in slot i; slot 0 is the oldest.
REQ-017 SHALL have port inst_pc_o, output, MULTI_ISSUE x DATA_WIDTH: PC of slot i.
REQ-018 SHALL have port consume_cnt_i, input, $clog2(MULTI_ISSUE)+1: number of slots taken this cycle, oldest first.

Function
REQ-019 SHALL keep a circular queue of DEPTH entries, each an instruction plus its PC, with head pointer, tail pointer and count 0..DEPTH; both pointers wrap modulo DEPTH.
REQ-020 SHALL drive inst_valid_o[i] = (count > i), with slot i taken from entry head+i (wrapping); inst_o and inst_pc_o are don't-care when not valid.
REQ-021 SHALL clamp consume_cnt_i to the number of valid slots, then advance head and decrease count by the clamped value.
REQ-022 SHALL use a three-state machine: IDLE (no request outstanding), WAIT (one request outstanding), DISCARD (outstanding request whose data must be dropped).
REQ-023 SHALL assert imem_rd_en_o combinationally in IDLE only, when not redirecting, not in reset, and free entries (DEPTH minus count) >= FETCH_WIDTH/32.
REQ-024 SHALL drive imem_addr_o = fetch_pc with the low $clog2(FETCH_WIDTH/8) bits cleared.
REQ-025 SHALL treat a request as accepted when imem_rd_en_o && !imem_busy_i; on acceptance IDLE->WAIT; at most one request is outstanding.
REQ-026 SHALL, on imem_rdy_i in WAIT, write the word's instructions at tail in address order, skipping any instruction whose address is below fetch_pc (misaligned entry after a redirect).
REQ-027 SHALL, on the same response, advance fetch_pc to the next aligned fetch boundary and go WAIT->IDLE; a request may be issued again in the following cycle.
REQ-028 SHALL apply a response write and a consume in the same cycle together; count changes by written minus consumed.
REQ-029 SHALL ignore imem_rdy_i in IDLE.
REQ-030 SHALL, on redirect_en_i, set head = tail, count = 0, fetch_pc = redirect_pc_i, and move WAIT->DISCARD; other states go to or stay in IDLE.
REQ-031 SHALL give redirect priority over any consume or response in the same cycle; such a response is dropped.
REQ-032 SHALL, in DISCARD, drop the next imem_rdy_i data and go to IDLE; a redirect received in DISCARD updates fetch_pc and stays in DISCARD.
REQ-033 SHALL never overflow the queue: the check in REQ-023 guarantees room for a full word when the response arrives.

Reset
REQ-034 SHALL, with rst high at a clock edge, set state IDLE, head = tail = count = 0, fetch_pc = RESET_PC; reset overrides redirect.
REQ-035 SHALL hold imem_rd_en_o = 0 and all inst_valid_o = 0 while rst is high.
REQ-036 SHALL drop any imem response to a request issued before reset (entry to DISCARD is not required; the data is never written).

Verification
REQ-037 SHALL cover this case: after reset, with busy=0, a response arriving 2 cycles later with data 0x00000013_00100093 -> imem_addr_o=0; slot0 = 0x00100093 at PC 0; slot1 = 0x00000013 at PC 4; next request to address 8.
REQ-038 SHALL cover this case: no consume until 8 entries are held -> count=8, imem_rd_en_o stays 0; after consume_cnt=2, one request is issued the next cycle.
REQ-039 SHALL cover this case: redirect to 0x104 while in WAIT -> the outstanding response is dropped; next request to 0x100; only 0x104's instruction is enqueued, at PC 0x104.
REQ-040 SHALL cover this case: consume_cnt=2 with a response in the same cycle and count=3 -> count=3 afterwards, and the order of entries is preserved across the wrap point.
REQ-041 SHALL cover this case: consume_cnt=2 with count=1 -> clamped to 1; count=0.
REQ-042 SHALL cover this case: imem_busy_i held high for 5 cycles -> imem_rd_en_o and imem_addr_o are stable throughout; a single request is accepted when busy drops.
